// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   AES ShiftRows / InvShiftRows stage for a DIM x DIM state of CELL_W-bit
//   cells. Each row r is rotated cyclically by r cells: left for ShiftRows,
//   right for InvShiftRows. The mode is chosen per transaction by in_inv.
//   The result is registered behind a valid/ready handshake. A 1-entry skid
//   buffer keeps full throughput with 1-cycle latency.
//
//   Cell k = c*DIM + r (column-major); cell 0 occupies the MSBs of a state.
//
// Parameters
//   DIM     rows = columns of the state (2..8)
//   CELL_W  bits per cell
//   SW      state width, DIM*DIM*CELL_W (derived)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input transaction valid
//   in_ready   out  block can accept (registered)
//   in_inv     in   0 = ShiftRows, 1 = InvShiftRows, travels with in_data
//   in_data    in   input state (SW bits)
//   out_valid  out  output transaction valid
//   out_ready  in   consumer accepts
//   xfer_cnt   out  16-bit count of output handshakes (optional, see below)
//   out_data   out  shifted state (SW bits)
//
// Configuration
//   SHIFT_ROWS_XFER_CNT_EN  when defined, adds the xfer_cnt port and its
//                           wrapping 16-bit output-handshake counter.

module shift_rows_pipe #(
  parameter  int DIM    = 4,
  parameter  int CELL_W = 8,
  localparam int SW     = DIM * DIM * CELL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic [SW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef SHIFT_ROWS_XFER_CNT_EN
  output logic [15:0]   xfer_cnt,
`endif
  output logic [SW-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   or_q;
  logic [SW-1:0]   sk_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [SW-1:0]   perm_fwd;
  logic [SW-1:0]   perm_inv;
  logic [SW-1:0]   perm;
  logic            accept;

  // Pure wiring: every destination cell picks its source cell through
  // elaboration-time constant indices, so no index arithmetic is synthesised.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      localparam int DST = c * DIM + r;
      localparam int FWD = ((c + r) % DIM) * DIM + r;
      localparam int INV = ((c - r + DIM) % DIM) * DIM + r;
      assign perm_fwd[SW-1-DST*CELL_W -: CELL_W] = in_data[SW-1-FWD*CELL_W -: CELL_W];
      assign perm_inv[SW-1-DST*CELL_W -: CELL_W] = in_data[SW-1-INV*CELL_W -: CELL_W];
    end
  end

  assign perm   = in_inv ? perm_inv : perm_fwd;
  assign accept = in_valid & in_ready_q;

  // OR always holds the oldest state; SK only fills when a new state arrives
  // while OR is stalled. in_ready drops only in TWO, so no state is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      or_q        <= '0;
      sk_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            or_q        <= perm;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && out_ready) begin
            or_q <= perm;
          end else if (accept) begin
            sk_q       <= perm;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            or_q       <= sk_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_q;

`ifdef SHIFT_ROWS_XFER_CNT_EN
  // Free-running count of output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 16'd0;
    end else if (out_valid_q && out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`else
  // No transfer counter in this build.
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe
//   Self-checking bench for shift_rows_pipe: a DIM=4/CELL_W=8 instance for
//   the main scenarios and a DIM=2/CELL_W=4 instance for the small case.
//   Expected states come from a rotation model computed directly from the
//   row/column rotation rule, held in an in-order queue.

module tb_shift_rows_pipe;

  localparam int DIM    = 4;
  localparam int CELL_W = 8;
  localparam int SW     = DIM * DIM * CELL_W;
  localparam int D2_SW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_inv;
  logic [SW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;

  logic             d2_in_valid;
  logic             d2_in_ready;
  logic             d2_in_inv;
  logic [D2_SW-1:0] d2_in_data;
  logic             d2_out_valid;
  logic             d2_out_ready;
  logic [D2_SW-1:0] d2_out_data;

`ifdef SHIFT_ROWS_XFER_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] d2_xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [SW-1:0] exp_q[$];

  always #5 clk = ~clk;

  shift_rows_pipe #(.DIM(DIM), .CELL_W(CELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFT_ROWS_XFER_CNT_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_data  (out_data)
  );

  shift_rows_pipe #(.DIM(2), .CELL_W(4)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d2_in_valid),
    .in_ready  (d2_in_ready),
    .in_inv    (d2_in_inv),
    .in_data   (d2_in_data),
    .out_valid (d2_out_valid),
    .out_ready (d2_out_ready),
`ifdef SHIFT_ROWS_XFER_CNT_EN
    .xfer_cnt  (d2_xfer_cnt),
`endif
    .out_data  (d2_out_data)
  );

  // Reference: treat the state as a dim x dim grid of cw-bit cells and rotate
  // row r by r places (left for forward, right for inverse).
  function automatic logic [127:0] ref_shift(input logic [127:0] d, input int dim,
                                             input int cw, input logic inv);
    int sw;
    int src_c;
    logic [127:0] o;
    sw = dim * dim * cw;
    o  = '0;
    for (int r = 0; r < dim; r++) begin
      for (int c = 0; c < dim; c++) begin
        src_c = inv ? (c - r + dim) % dim : (c + r) % dim;
        for (int b = 0; b < cw; b++)
          o[sw-1-(c*dim+r)*cw-b] = d[sw-1-(src_c*dim+r)*cw-b];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [SW-1:0] d, input logic inv, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_inv    = inv;
    out_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_inv = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data); end
    checks++;
    if (d2_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_d2_out_valid: got %b, expected 0", d2_out_valid); end
`ifdef SHIFT_ROWS_XFER_CNT_EN
    checks++;
    if (xfer_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_xfer_cnt: got %0d, expected 0", xfer_cnt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid: got %b, expected 0", out_valid); end
    xfers = 0;
    exp_q.delete();
  endtask

  task automatic test_dim2();
    logic [D2_SW-1:0] r;
    logic [127:0] e;
    r = D2_SW'($urandom);
    @(negedge clk);
    d2_in_valid = 1'b1; d2_in_data = 16'h1234; d2_in_inv = 1'b0; d2_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d2_out_valid !== 1'b1 || d2_out_data !== 16'h1432) begin
      errors++; $display("[TB] FAIL dim2_fwd: got v=%b %h, expected v=1 1432", d2_out_valid, d2_out_data);
    end
    d2_in_data = 16'h1432; d2_in_inv = 1'b1;
    @(negedge clk);
    checks++;
    if (d2_out_valid !== 1'b1 || d2_out_data !== 16'h1234) begin
      errors++; $display("[TB] FAIL dim2_inv: got v=%b %h, expected v=1 1234", d2_out_valid, d2_out_data);
    end
    d2_in_data = r; d2_in_inv = 1'b0;
    e = ref_shift({112'b0, r}, 2, 4, 1'b0);
    @(negedge clk);
    checks++;
    if (d2_out_valid !== 1'b1 || d2_out_data !== e[15:0]) begin
      errors++; $display("[TB] FAIL dim2_rand: got v=%b %h, expected v=1 %h", d2_out_valid, d2_out_data, e[15:0]);
    end
    d2_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d2_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dim2_idle: got %b, expected 0", d2_out_valid); end
`ifdef SHIFT_ROWS_XFER_CNT_EN
    checks++;
    if (d2_xfer_cnt !== 16'd3) begin errors++; $display("[TB] FAIL dim2_xfer_cnt: got %0d, expected 3", d2_xfer_cnt); end
`endif
  endtask

  task automatic test_vectors();
    drive(1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0, 1'b1);
    drive(1'b1, 128'h00050a0f_04090e03_080d0207_0c01060b, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 128'h00050a0f_04090e03_080d0207_0c01060b) begin
      errors++; $display("[TB] FAIL vec_fwd: got v=%b %h, expected v=1 00050a0f04090e03080d02070c01060b", out_valid, out_data);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 128'h00010203_04050607_08090a0b_0c0d0e0f) begin
      errors++; $display("[TB] FAIL vec_inv: got v=%b %h, expected v=1 000102030405060708090a0b0c0d0e0f", out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL vec_drain: got out_valid %b, expected 0", out_valid); end
    xfers += 2;
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] a, b, c;
    logic c_sent;
    int emitted;
    a = rand128(); b = rand128(); c = rand128();
    emitted = 0;
    c_sent  = 1'b0;
    drive(1'b1, a, 1'b0, 1'b0);
    if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, DIM, CELL_W, in_inv));
    drive(1'b1, b, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one: got %b, expected 1", in_ready); end
    if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, DIM, CELL_W, in_inv));
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, c, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_two: got %b, expected 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== ref_shift(a, DIM, CELL_W, 1'b0)) begin
        errors++; $display("[TB] FAIL bp_hold: got v=%b %h, expected v=1 %h", out_valid, out_data, ref_shift(a, DIM, CELL_W, 1'b0));
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(!c_sent, c, 1'b0, 1'b1);
      if (out_valid && out_ready) begin
        checks++; emitted++; xfers++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL bp_order: got spurious %h, expected no output", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL bp_order: got %h, expected %h", out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, DIM, CELL_W, in_inv));
        c_sent = 1'b1;
      end
    end
    checks++;
    if (emitted != 3 || exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL bp_count: got %0d outputs (%0d pending), expected 3 (0 pending)", emitted, exp_q.size());
    end
  endtask

  task automatic test_streaming();
    int emitted;
    emitted = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i < 10, rand128(), i[0], 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready[%0d]: got %b, expected 1", i, in_ready); end
      checks++;
      if (out_valid !== (i >= 1 && i <= 10)) begin
        errors++; $display("[TB] FAIL stream_valid[%0d]: got %b, expected %b", i, out_valid, (i >= 1 && i <= 10));
      end
      if (out_valid && out_ready) begin
        checks++; emitted++; xfers++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL stream_data[%0d]: got spurious %h, expected no output", i, out_data);
        end else begin
          if (out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h, expected %h", i, out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, DIM, CELL_W, in_inv));
    end
    checks++;
    if (emitted != 10) begin errors++; $display("[TB] FAIL stream_count: got %0d, expected 10", emitted); end
  endtask

  task automatic test_random();
    logic          prev_stall;
    logic [SW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int i = 0; i < 308; i++) begin
      if (i < 300)
        drive(($urandom % 4) != 0, rand128(), 1'($urandom), ($urandom % 3) != 0);
      else
        drive(1'b0, '0, 1'b0, 1'b1);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("[TB] FAIL rand_stable[%0d]: got v=%b %h, expected v=1 %h", i, out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        checks++; xfers++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand_data[%0d]: got spurious %h, expected no output", i, out_data);
        end else begin
          if (out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h, expected %h", i, out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, DIM, CELL_W, in_inv));
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rand_drain: got %0d pending, out_valid %b, expected 0 pending, 0", exp_q.size(), out_valid);
    end
`ifdef SHIFT_ROWS_XFER_CNT_EN
    checks++;
    if (xfer_cnt !== xfers[15:0]) begin errors++; $display("[TB] FAIL rand_xfer_cnt: got %0d, expected %0d", xfer_cnt, xfers[15:0]); end
`endif
  endtask

  task automatic test_reset_mid_op();
    drive(1'b1, rand128(), 1'b0, 1'b0);
    drive(1'b1, rand128(), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_full: got ready=%b valid=%b, expected ready=0 valid=1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("[TB] FAIL midrst_async: got v=%b %h, expected v=0 0", out_valid, out_data);
    end
    exp_q.delete();
    xfers = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midrst_after[%0d]: got ready=%b valid=%b, expected ready=1 valid=0", i, in_ready, out_valid);
      end
    end
`ifdef SHIFT_ROWS_XFER_CNT_EN
    checks++;
    if (xfer_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midrst_xfer_cnt: got %0d, expected 0", xfer_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_dim2();
    test_vectors();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
